booth_ctrl: RTL and testbench

//  Radix-2 Booth multiplier sequencer: FSM + iteration counter driving the shift/load registers
//  (accumulator A, multiplier Q, Q[-1] flop, multiplicand M) and the add/sub unit.

---
 rtl/booth_pkg.sv | 39 +++
 rtl/booth_iter_cnt.sv | 52 +++++
 rtl/booth_ctrl.sv | 122 ++++++++++++
 tb/tb_booth_ctrl.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/booth_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : booth_pkg
//  Description : Shared types and constants for the radix-2 Booth sequencer:
//                FSM state encoding, Booth pair codes and the pair decoder.
//  Revision    : 1.0 - initial release
// ============================================================================
package booth_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        ARITH = 3'd2,
        SHIFT = 3'd3,
        DONE  = 3'd4
    } booth_state_t;

    // Booth pair codes for {Q[0], Q[-1]}
    localparam logic [1:0] BOOTH_NOP0 = 2'b00;
    localparam logic [1:0] BOOTH_ADD  = 2'b01;
    localparam logic [1:0] BOOTH_SUB  = 2'b10;
    localparam logic [1:0] BOOTH_NOP1 = 2'b11;

    // Maps a Booth pair to {alu_en, alu_sub}; alu_sub is forced low on no-ops
    function automatic logic [1:0] booth_decode(input logic [1:0] pair);
        logic [1:0] ctl;
        ctl = 2'b00;
        case (pair)
            BOOTH_ADD:  ctl = 2'b10;
            BOOTH_SUB:  ctl = 2'b11;
            BOOTH_NOP0: ctl = 2'b00;
            BOOTH_NOP1: ctl = 2'b00;
            default:    ctl = 2'b00;
        endcase
        return ctl;
    endfunction

endpackage
`default_nettype wire

// File: rtl/booth_iter_cnt.sv
`default_nettype none
// ============================================================================
//  Module      : booth_iter_cnt
//  Description : Booth iteration counter. Clears to zero, increments on
//                request and saturates at WIDTH-1; last flags the final
//                iteration.
//  Revision    : 1.0 - initial release
// ============================================================================
module booth_iter_cnt #(
    parameter int WIDTH = 8,
    parameter int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             last_o
);

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             last_w;

    assign last_w = (cnt_q == LAST_IDX);

    // Next count: clear has priority, increment never wraps past the last index
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && !last_w) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Counter register
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o  = cnt_q;
    assign last_o = last_w;

endmodule
`default_nettype wire

// File: rtl/booth_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : booth_ctrl
//  Description : Radix-2 Booth multiplier sequencer. Accepts a start request,
//                loads operands, runs WIDTH ARITH/SHIFT iterations and pulses
//                done. Control outputs are decoded from the FSM state.
//                Optional feature macro: BOOTH_CTRL_ABORT_EN adds an abort
//                input that returns any active run to IDLE without done.
//  Revision    : 1.0 - initial release
// ============================================================================
module booth_ctrl
    import booth_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic             clk,
    input  logic             rst,
`ifdef BOOTH_CTRL_ABORT_EN
    input  logic             abort,
`endif
    input  logic             start,
    input  logic             q_lsb,
    input  logic             q_m1,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic             load_en,
    output logic             alu_en,
    output logic             alu_sub,
    output logic             shift_en,
    output logic [CNT_W-1:0] iter
);

    booth_state_t     state_q;
    booth_state_t     state_d;
    logic             abort_w;
    logic             cnt_clr_w;
    logic             cnt_inc_w;
    logic             cnt_last_w;
    logic [CNT_W-1:0] cnt_w;

`ifdef BOOTH_CTRL_ABORT_EN
    // Abort only matters once a run is in flight
    assign abort_w = abort && (state_q != IDLE);
`else
    assign abort_w = 1'b0;
`endif

    // Counter sits at zero whenever no run is active, so LOAD always sees 0
    assign cnt_clr_w = (state_q == IDLE) || (state_q == DONE) || abort_w;
    assign cnt_inc_w = (state_q == SHIFT);

    booth_iter_cnt #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_iter_cnt (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (cnt_clr_w),
        .inc_i  (cnt_inc_w),
        .cnt_o  (cnt_w),
        .last_o (cnt_last_w)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; abort overrides every transition including start
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = LOAD;
            LOAD:    state_d = ARITH;
            ARITH:   state_d = SHIFT;
            SHIFT:   state_d = cnt_last_w ? DONE : ARITH;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (abort_w) begin
            state_d = IDLE;
        end
    end

    // Output decode from state; ARITH qualifies the ALU with the Booth pair
    always_comb begin
        ready    = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        load_en  = 1'b0;
        alu_en   = 1'b0;
        alu_sub  = 1'b0;
        shift_en = 1'b0;
        case (state_q)
            IDLE:  ready = 1'b1;
            LOAD: begin
                busy    = 1'b1;
                load_en = 1'b1;
            end
            ARITH: begin
                busy              = 1'b1;
                {alu_en, alu_sub} = booth_decode({q_lsb, q_m1});
            end
            SHIFT: begin
                busy     = 1'b1;
                shift_en = 1'b1;
            end
            DONE:  done = 1'b1;
            default: ready = 1'b0;
        endcase
    end

    assign iter = cnt_w;

endmodule
`default_nettype wire

// File: tb/tb_booth_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_booth_ctrl
//  Description : Self-checking bench for booth_ctrl. A small A:Q:Q[-1]:M
//                datapath is driven by the DUT controls; each accepted start
//                queues the arithmetic product and Booth op count, and a
//                monitor checks them when done pulses.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_booth_ctrl;

    localparam int W   = 8;
    localparam int CW  = 3;
    localparam int LAT = 2 * W + 1;   // edges from accepting edge to done
    localparam int PER = 2 * W + 3;   // run period with start held high

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          q_lsb;
    logic          q_m1;
    logic          ready, busy, done, load_en, alu_en, alu_sub, shift_en;
    logic [CW-1:0] iter;
`ifdef BOOTH_CTRL_ABORT_EN
    logic          abort;
`endif

    booth_ctrl #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst      (rst),
`ifdef BOOTH_CTRL_ABORT_EN
        .abort    (abort),
`endif
        .start    (start),
        .q_lsb    (q_lsb),
        .q_m1     (q_m1),
        .ready    (ready),
        .busy     (busy),
        .done     (done),
        .load_en  (load_en),
        .alu_en   (alu_en),
        .alu_sub  (alu_sub),
        .shift_en (shift_en),
        .iter     (iter)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2*W-1:0] prod;
        int             edge_n;
        int             alus;
    } exp_t;

    exp_t           exp_q[$];
    int             done_log[$];
    int             edge_cnt = 0;
    int             nvec = 0;
    int             nfail = 0;

    logic [W:0]     dp_a;
    logic [W-1:0]   dp_q, dp_m;
    logic           dp_qm1;
    logic [W-1:0]   op_q, op_m;

    assign q_lsb = dp_q[0];
    assign q_m1  = dp_qm1;

    // Reference: signed product and number of bit transitions in Q (with Q[-1]=0)
    function automatic exp_t model(input logic [W-1:0] q, input logic [W-1:0] m, input int e);
        exp_t                  r;
        logic signed [2*W-1:0] p;
        logic                  prev;
        p = $signed({{W{m[W-1]}}, m}) * $signed({{W{q[W-1]}}, q});
        r.prod   = p;
        r.edge_n = e;
        r.alus   = 0;
        prev     = 1'b0;
        for (int i = 0; i < W; i++) begin
            if (q[i] != prev) r.alus++;
            prev = q[i];
        end
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        nvec++;
        if (act !== expv) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", nm, act, expv, edge_cnt);
        end
    endtask

    // Datapath model and scoreboard push on accepted start
    always @(posedge clk) begin
        edge_cnt <= edge_cnt + 1;
        if (rst) begin
            exp_q.delete();
            dp_a   <= '0;
            dp_q   <= '0;
            dp_m   <= '0;
            dp_qm1 <= 1'b0;
        end else begin
            if (ready && start) exp_q.push_back(model(op_q, op_m, edge_cnt + 1));
`ifdef BOOTH_CTRL_ABORT_EN
            if (abort && !ready) exp_q.delete();
`endif
            if (load_en) begin
                dp_a   <= '0;
                dp_q   <= op_q;
                dp_m   <= op_m;
                dp_qm1 <= 1'b0;
            end else if (alu_en) begin
                dp_a <= alu_sub ? dp_a - {dp_m[W-1], dp_m} : dp_a + {dp_m[W-1], dp_m};
            end else if (shift_en) begin
                dp_a   <= {dp_a[W], dp_a[W:1]};
                dp_q   <= {dp_a[0], dp_q[W-1:1]};
                dp_qm1 <= dp_q[0];
            end
        end
    end

    // Monitor: structural checks every cycle, scoreboard pop on done
    initial begin : mon
        int   run_alu;
        int   run_shift;
        exp_t e;
        run_alu   = 0;
        run_shift = 0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                chk("one_status", 32'(ready) + 32'(busy) + 32'(done), 1);
                chk("excl_en", (32'(load_en) + 32'(alu_en) + 32'(shift_en)) > 1 ? 1 : 0, 0);
                chk("sub_no_alu", (alu_sub && !alu_en) ? 1 : 0, 0);
                if (load_en) begin
                    run_alu   = 0;
                    run_shift = 0;
                end
                if (busy) chk("iter", 32'(iter), run_shift);
                if (ready) chk("iter_idle", 32'(iter), 0);
                if (alu_en) run_alu++;
                if (shift_en) run_shift++;
                if (done) begin
                    if (exp_q.size() == 0) begin
                        chk("spurious_done", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("product", 32'({dp_a[W-1:0], dp_q}), 32'(e.prod));
                        chk("latency", edge_cnt - e.edge_n, LAT);
                        chk("alu_ops", run_alu, e.alus);
                        chk("shifts", run_shift, W);
                    end
                    done_log.push_back(edge_cnt);
                end
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_ready();
        int t;
        t = 0;
        while (!ready && t < 200) begin
            cyc(1);
            t++;
        end
        if (!ready) chk("timeout_ready", 0, 1);
    endtask

    // Start one run and leave the bench just after the accepting edge
    task automatic launch(input logic [W-1:0] q, input logic [W-1:0] m);
        wait_ready();
        op_q  = q;
        op_m  = m;
        start = 1'b1;
        cyc(1);
        start = 1'b0;
    endtask

    initial begin : drv
        int t;
        rst   = 1'b1;
        start = 1'b1;
        op_q  = '0;
        op_m  = '0;
`ifdef BOOTH_CTRL_ABORT_EN
        abort = 1'b0;
`endif
        // Reset with start held high
        cyc(2);
        chk("rst_ready", 32'(ready), 1);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_load", 32'(load_en), 0);
        chk("rst_alu", 32'(alu_en), 0);
        chk("rst_shift", 32'(shift_en), 0);
        chk("rst_iter", 32'(iter), 0);
        rst   = 1'b0;
        start = 1'b0;
        cyc(1);

        // Directed operands
        launch(8'h03, 8'h05);
        launch(8'hFE, 8'h07);
        launch(8'h80, 8'h80);
        launch(8'h7F, 8'h81);

        // Start pulses mid-run and in DONE must be ignored
        launch(8'h5A, 8'hC3);
        cyc(3);
        start = 1'b1;
        cyc(1);
        start = 1'b0;
        cyc(13);
        start = 1'b1;
        cyc(1);
        start = 1'b0;
        wait_ready();
        cyc(3);

        // Start held high: back-to-back runs
        done_log.delete();
        op_q  = 8'h96;
        op_m  = 8'h2B;
        start = 1'b1;
        t = 0;
        while (done_log.size() < 3 && t < 100) begin
            cyc(1);
            t++;
        end
        start = 1'b0;
        if (done_log.size() < 3) begin
            chk("held_runs", done_log.size(), 3);
        end else begin
            chk("held_gap1", done_log[1] - done_log[0], PER);
            chk("held_gap2", done_log[2] - done_log[1], PER);
        end
        wait_ready();

        // Reset in the middle of a run
        launch(8'h33, 8'h44);
        cyc(7);
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        chk("midrst_ready", 32'(ready), 1);
        chk("midrst_busy", 32'(busy), 0);
        cyc(25);
        launch(8'hE7, 8'h19);

`ifdef BOOTH_CTRL_ABORT_EN
        // Abort mid-run
        launch(8'h6D, 8'hA2);
        cyc(5);
        abort = 1'b1;
        cyc(1);
        abort = 1'b0;
        chk("abort_ready", 32'(ready), 1);
        chk("abort_iter", 32'(iter), 0);
        cyc(25);
        // Abort and start together in ARITH
        launch(8'h11, 8'h22);
        cyc(1);
        abort = 1'b1;
        start = 1'b1;
        cyc(1);
        abort = 1'b0;
        start = 1'b0;
        chk("abort_start_ready", 32'(ready), 1);
        chk("abort_start_load", 32'(load_en), 0);
        cyc(25);
        // Abort is ignored in IDLE
        wait_ready();
        op_q  = 8'h0F;
        op_m  = 8'hF0;
        abort = 1'b1;
        start = 1'b1;
        cyc(1);
        abort = 1'b0;
        start = 1'b0;
        chk("abort_idle_load", 32'(load_en), 1);
`endif

        // Randomised runs with start noise while busy
        for (int n = 0; n < 24; n++) begin
            wait_ready();
            cyc($urandom_range(0, 3));
            launch(W'($urandom), W'($urandom));
            for (int k = 0; k < 2 * W; k++) begin
                start = $urandom_range(0, 1) == 1;
                cyc(1);
            end
            start = 1'b0;
        end
        wait_ready();
        cyc(5);
        chk("pending", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
`default_nettype wire
